ehgu_ram_sdp_pipe: RTL
======================

# ehgu_ram_sdp_pipe

Single-clock simple-dual-port RAM: the parametrised successor to the team's basic dual-port RAM. It adds byte-write enables, a selectable 1- or 2-cycle read pipeline with an `rvalid` qualifier, and a selectable read-during-write policy. A post-reset clear sequencer zeroes the array. Optional per-byte parity is also available. It sits under the ehgu buffers and tables as the common storage primitive.

## Interface
- `DEPTH`, 16: number of words; need not be a power of 2.
- `WIDTH`, 32: word width; must be a multiple of `BYTE_W`.
- `BYTE_W`, 8: bits per write-enable lane; NB = `WIDTH/BYTE_W`.
- `RD_LAT`, 1: read latency in cycles; legal values are 1 or 2.
- `RDW_MODE`, 0: same-address read/write in the same cycle; 0 = old data, 1 = new (merged) data.
- `CLR_ON_RST`, 1: 1 = zero the whole array after reset.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `init_done`  out  1  high once the array is usable.
- `wenable`  in  1  write request.
- `waddr`  in  $clog2(DEPTH)  write address.
- `wdata`  in  WIDTH  write data.
- `wbe`  in  NB  byte-lane write enables; bit i covers `wdata[i*BYTE_W +: BYTE_W]`.
- `winj_par`  in  1  inverts the stored parity bits of this write (error injection).
- `renable`  in  1  read request.
- `raddr`  in  $clog2(DEPTH)  read address.
- `rdata`  out  WIDTH  read data.
- `rvalid`  out  1  `rdata` is valid this cycle.
- `rerr`  out  1  parity error on the current `rvalid` word.

## Operation
- Reset (`rst_n` low): `rdata`=0, `rvalid`=0, `rerr`=0, `init_done`=0, read pipeline flushed, clear counter=0.
- Array contents are not reset; they are changed only by writes or by the clear sequence.
- FSM has two states, CLEAR and READY.
- With `CLR_ON_RST`=1, the FSM enters CLEAR after reset release. It writes zero (with correct parity) to address k on cycle k, for k = 0..DEPTH-1, then enters READY.
- While in CLEAR: `wenable` and `renable` are ignored, `rvalid` stays 0, `init_done` stays 0.
- With `CLR_ON_RST`=0, the FSM goes straight to READY.
- `init_done` = (state==READY), registered.
- Reset asserted during CLEAR aborts the sequence; it restarts from address 0 on release.
- Write (READY): when `wenable` is high, only lanes with `wbe[i]`=1 are updated; `wbe`=0 is a no-op.
- Read (READY): `renable` at edge N gives `rdata`/`rvalid` at edge N+`RD_LAT`.
- Back-to-back reads are accepted every cycle, with no bubbles.
- With `rvalid`=0, `rdata` holds its last value; it never goes X.
- Same-cycle read/write to the same address:
  - `RDW_MODE`=0: the read returns pre-write contents.
  - `RDW_MODE`=1: the read returns the merge, i.e. `wdata` on lanes with `wbe`=1 and old contents on the other lanes.
- With `RD_LAT`=2, a write on the cycle after a read is accepted does not affect that read; the array is sampled in stage 1.
- Out-of-range address (>= DEPTH): the write is dropped; the read returns 0 with `rvalid`=1 and `rerr`=0.
- Same-address read/write warning: under `ifndef SYNTHESIS`, the block prints a `$display` when the read and write addresses match in the same cycle.

## Timing
- `init_done` rises exactly DEPTH+1 edges after the first edge with `rst_n` high when `CLR_ON_RST`=1, and 1 edge after when it is 0.
- Read latency is fixed at `RD_LAT`; `rvalid` is a pure `RD_LAT`-delayed copy of (`renable` && READY).
- A write at edge N is visible to a read issued at edge N+1 in either RDW mode.
- `rerr` is registered alongside `rdata` and is only meaningful when `rvalid`=1; otherwise it is 0.

## Configuration
- `EHGU_RAM_PARITY_EN` defined:
  - Each lane stores one extra even-parity bit over its data byte.
  - `winj_par`=1 inverts the parity bits of the enabled lanes being written.
  - On read, `rerr`=1 if any lane mismatches.
  - In RDW_MODE=1 merged reads, parity of the bypassed lanes is taken from the write path.
- `EHGU_RAM_PARITY_EN` undefined: no parity storage, `winj_par` is ignored, and `rerr` is constant 0.

## Test plan
- Clear, DEPTH=16, CLR_ON_RST=1:
  - Preload garbage via a backdoor, then release reset.
  - `init_done` must rise at edge 17.
  - Reads of all 16 addresses must return 0 with `rvalid` one cycle later.
- Byte enables, WIDTH=32:
  - Write 0xAABBCCDD to addr 3 with `wbe`=4'hF, then 0x11223344 with `wbe`=4'b0101.
  - Reading addr 3 must return 0xAA22CC44.
- Read-during-write at addr 5 (holds 0x0), write 0xFFFF0000 with `wbe`=4'hF:
  - RDW_MODE=0 must return 0x00000000.
  - RDW_MODE=1 must return 0xFFFF0000.
  - A subsequent read must return 0xFFFF0000 in both modes.
- Latency, RD_LAT=2:
  - Issue reads on 4 consecutive cycles to addrs 0..3.
  - `rvalid` must be high for 4 cycles, starting 2 edges after the first read, with data in order and `rdata` held after the burst.
- Reset mid-clear:
  - Assert `rst_n` low at clear cycle 7, then release.
  - `init_done` must rise DEPTH+1 edges after release, and all words must read 0.
- Parity, with `EHGU_RAM_PARITY_EN`:
  - Write addr 2 with `winj_par`=1, then read it; `rerr` must be 1 with `rvalid`.
  - Rewrite with `winj_par`=0; the next read must give `rerr`=0.
  - DEPTH=12: write to addr 13 is dropped, and a read of addr 13 returns 0 with `rerr`=0.

Source files
------------

// File: rtl/ehgu_ram_sdp_pipe_if.sv
// Bus bundle for ehgu_ram_sdp_pipe: write port, read port and status.
// The master side drives requests; the RAM sits on the slave side.
interface ehgu_ram_sdp_pipe_if #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 32,
  parameter int BYTE_W = 8
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = WIDTH / BYTE_W;

  logic             init_done;
  logic             wenable;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [NB-1:0]    wbe;
  logic             winj_par;
  logic             renable;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             rerr;

  modport master (
    input  init_done, rdata, rvalid, rerr,
    output wenable, waddr, wdata, wbe, winj_par, renable, raddr
  );

  modport slave (
    output init_done, rdata, rvalid, rerr,
    input  wenable, waddr, wdata, wbe, winj_par, renable, raddr
  );
endinterface

// File: rtl/ehgu_ram_sdp_pipe.sv
// ehgu_ram_sdp_pipe: single-clock simple-dual-port RAM with byte enables,
// 1- or 2-cycle read pipeline, selectable read-during-write policy and a
// post-reset clear sequencer.
// Optional feature: define EHGU_RAM_PARITY_EN for one even-parity bit per
// byte lane, with write-side error injection and read-side error flag.
module ehgu_ram_sdp_pipe #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 32,
  parameter int BYTE_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  ehgu_ram_sdp_pipe_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = WIDTH / BYTE_W;
  localparam int unsigned DEPTH_U = DEPTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state, state_next;
  logic [AW-1:0] clr_cnt, clr_cnt_next;
  logic          clr_we;
  logic          init_q;
  logic          ready;
  logic          w_ok;
  logic          r_acc;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] rd_word;
  logic             rd_err;

  logic [WIDTH-1:0] s1_data;
  logic             s1_valid;
  logic             s1_err;

  assign ready = (state == READY);
  assign w_ok  = ready && bus.wenable && (32'(bus.waddr) < DEPTH_U);
  assign r_acc = ready && bus.renable;
  assign bus.init_done = init_q;

  // State register, clear address counter and registered init_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLR_ON_RST != 0) state <= CLEAR;
      else                 state <= READY;
      clr_cnt <= '0;
      init_q  <= 1'b0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
      init_q  <= (state == READY);
    end
  end

  // Clear sequencer: zero one word per cycle, then hand over to READY
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    clr_we       = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (32'(clr_cnt) == DEPTH_U - 32'd1) begin
          state_next   = READY;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt + AW'(1);
        end
      end
      READY: begin
        state_next = READY;
      end
    endcase
  end

  // Data array: clear writes take priority, user writes update enabled lanes
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (w_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wbe[i]) mem[bus.waddr][i*BYTE_W +: BYTE_W] <= bus.wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef EHGU_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wpar;
  logic [NB-1:0] rd_par;

  // Write-side parity per lane, optionally inverted for error injection
  always_comb begin
    wpar = '0;
    for (int i = 0; i < NB; i++) begin
      wpar[i] = (^bus.wdata[i*BYTE_W +: BYTE_W]) ^ bus.winj_par;
    end
  end

  // Parity array follows the data array lane by lane
  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_mem[clr_cnt] <= '0;
    end else if (w_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wbe[i]) par_mem[bus.waddr][i] <= wpar[i];
      end
    end
  end
`else
  logic unused_winj_par;
  assign unused_winj_par = bus.winj_par;
`endif

  // Read word selection: out-of-range reads give zero, optional write bypass
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
`ifdef EHGU_RAM_PARITY_EN
    rd_par  = '0;
`endif
    if (32'(bus.raddr) < DEPTH_U) begin
      rd_word = mem[bus.raddr];
`ifdef EHGU_RAM_PARITY_EN
      rd_par  = par_mem[bus.raddr];
`endif
      if ((RDW_MODE != 0) && w_ok && (bus.waddr == bus.raddr)) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.wbe[i]) begin
            rd_word[i*BYTE_W +: BYTE_W] = bus.wdata[i*BYTE_W +: BYTE_W];
`ifdef EHGU_RAM_PARITY_EN
            rd_par[i] = wpar[i];
`endif
          end
        end
      end
`ifdef EHGU_RAM_PARITY_EN
      for (int i = 0; i < NB; i++) begin
        if (rd_par[i] != (^rd_word[i*BYTE_W +: BYTE_W])) rd_err = 1'b1;
      end
`endif
    end
  end

  // Read stage 1: sample the array; data holds when no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= r_acc;
      s1_err   <= r_acc && rd_err;
      if (r_acc) s1_data <= rd_word;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] s2_data;
      logic             s2_valid;
      logic             s2_err;

      // Read stage 2: pure one-cycle delay of stage 1, holding data when idle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_valid && s1_err;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign bus.rdata  = s2_data;
      assign bus.rvalid = s2_valid;
      assign bus.rerr   = s2_err;
    end else begin : g_lat1
      assign bus.rdata  = s1_data;
      assign bus.rvalid = s1_valid;
      assign bus.rerr   = s1_err;
    end
  endgenerate

`ifndef SYNTHESIS
  // Simulation notice for same-address read/write collisions
  always @(posedge clk) begin
    if (rst_n && ready && bus.wenable && bus.renable && (bus.waddr == bus.raddr))
      $display("[ehgu_ram_sdp_pipe] %m: same-address read/write at addr %0d", bus.waddr);
  end
`endif
endmodule
